// File: rtl/race_pkg.sv
// Shared definitions for the race game controller: state encodings, layer colour
// limits and the active display area.
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam logic [9:0] LAST_COL = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LAST_ROW = 10'(V_ACTIVE - 1);

    // Black and white are background/transparent; anything between is a drawn pixel.
    function automatic logic pixel_set(input logic [11:0] colour);
        return (colour > COLOR_BLACK) && (colour < COLOR_WHITE);
    endfunction

endpackage

// File: rtl/race_controller_collision.sv
// Sticky overlap detector between the player-car and traffic layers; one register
// stage on the pixel flags, then a flag held until the controller clears it.
module collision_detect
    import race_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] player_px,
    input  logic [11:0] traffic_px,
    input  logic        video_on,
    input  logic        enable,
    input  logic        clear,
    output logic        collision
);

    logic player_set_q;
    logic traffic_set_q;
    logic video_on_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_set_q  <= 1'b0;
            traffic_set_q <= 1'b0;
            video_on_q    <= 1'b0;
            collision     <= 1'b0;
        end else begin
            player_set_q  <= pixel_set(player_px);
            traffic_set_q <= pixel_set(traffic_px);
            video_on_q    <= video_on;
            // Clear wins over a coinciding hit: the crash that clears it already consumed the frame.
            if (clear)
                collision <= 1'b0;
            else if (player_set_q && traffic_set_q && video_on_q && enable)
                collision <= 1'b1;
        end
    end

endmodule

// File: rtl/race_controller.sv
// Race game sequencer: frame tick decode, start-edge detect, scroll/score/lives
// bookkeeping and the IDLE/RUN/CRASH/OVER game flow.
module race_controller
    import race_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int CRASH_FRAMES = 120,
    parameter int SCORE_MAX    = 9999,
    parameter int ROAD_HEIGHT  = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic [11:0] player_car_in,
    input  logic [11:0] moving_cars_in,
    input  logic        start_btn,
    output logic [9:0]  road_scroll,
    output logic [2:0]  traffic_speed,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  game_state,
    output logic        crash_pulse
);

    localparam logic [10:0] ROAD_H     = 11'(ROAD_HEIGHT);
    localparam logic [13:0] SCORE_LIM  = 14'(SCORE_MAX);
    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [15:0] CRASH_LAST = 16'(CRASH_FRAMES - 1);

    game_state_t state_q, state_d;
    logic [13:0] score_d;
    logic [9:0]  scroll_d;
    logic [1:0]  lives_d;
    logic [15:0] crash_cnt_q, crash_cnt_d;
    logic        frame_tick;
    logic        start_q;
    logic        start_edge;
    logic        collision;
    logic        coll_clear;
    logic [10:0] scroll_sum;
    logic [9:0]  scroll_next;
    logic [4:0]  speed_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            frame_tick <= video_on && (pix_row == LAST_ROW) && (pix_col == LAST_COL);
            start_q    <= start_btn;
        end
    end

    assign start_edge = start_btn && !start_q;

    collision_detect u_collision (
        .clk        (clk),
        .reset      (reset),
        .player_px  (player_car_in),
        .traffic_px (moving_cars_in),
        .video_on   (video_on),
        .enable     (state_q == ST_RUN),
        .clear      (coll_clear),
        .collision  (collision)
    );

    // Speed ramps by one every 1024 frames of score, capped at 7.
    always_comb begin
        speed_raw = 5'd2 + {1'b0, score[13:10]};
        if (state_q == ST_IDLE || state_q == ST_OVER)
            traffic_speed = 3'd0;
        else if (speed_raw > 5'd7)
            traffic_speed = 3'd7;
        else
            traffic_speed = speed_raw[2:0];
    end

    assign scroll_sum  = {1'b0, road_scroll} + {8'd0, traffic_speed};
    assign scroll_next = 10'((scroll_sum >= ROAD_H) ? (scroll_sum - ROAD_H) : scroll_sum);

    always_comb begin
        state_d     = state_q;
        score_d     = score;
        scroll_d    = road_scroll;
        lives_d     = lives;
        crash_cnt_d = crash_cnt_q;
        crash_pulse = 1'b0;
        coll_clear  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d    = ST_RUN;
                    score_d    = 14'd0;
                    scroll_d   = 10'd0;
                    lives_d    = LIVES_LOAD;
                    coll_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    if (collision) begin
                        crash_pulse = 1'b1;
                        coll_clear  = 1'b1;
                        lives_d     = lives - 2'd1;
                        crash_cnt_d = 16'd0;
                        state_d     = (lives == 2'd1) ? ST_OVER : ST_CRASH;
                    end else begin
                        scroll_d = scroll_next;
                        if (score < SCORE_LIM)
                            score_d = score + 14'd1;
                    end
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    crash_cnt_d = crash_cnt_q + 16'd1;
                    if (crash_cnt_d == CRASH_LAST)
                        state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            score       <= 14'd0;
            road_scroll <= 10'd0;
            lives       <= LIVES_LOAD;
            crash_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            score       <= score_d;
            road_scroll <= scroll_d;
            lives       <= lives_d;
            crash_cnt_q <= crash_cnt_d;
        end
    end

    assign game_state = state_q;

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start.
REQ-002 SHALL have parameter CRASH_FRAMES, default 120: frames frozen after a non-final crash.
REQ-003 SHALL have parameter SCORE_MAX, default 9999: score saturation value.
REQ-004 SHALL have parameter ROAD_HEIGHT, default 480: scroll wrap modulus.
REQ-005 SHALL have port clk  input  1: single system clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-007 SHALL have ports pix_row, pix_col  input  10 each: current pixel location from the display timing generator.
REQ-008 SHALL have port video_on  input  1: active display region.
REQ-009 SHALL have ports player_car_in, moving_cars_in  input  12 each: layer pixel colours.
REQ-010 SHALL have port start_btn  input  1: debounced start button, level.
REQ-011 SHALL have port road_scroll  output  10: road vertical offset, 0..ROAD_HEIGHT-1.
REQ-012 SHALL have port traffic_speed  output  3: pixels per frame, 0..7.
REQ-013 SHALL have port score  output  14: frames survived, saturating.
REQ-014 SHALL have port lives  output  2: remaining lives.
REQ-015 SHALL have port game_state  output  2: IDLE=0, RUN=1, CRASH=2, OVER=3.
REQ-016 SHALL have port crash_pulse  output  1: one-cycle pulse per detected collision.

Function
REQ-017 SHALL treat a layer pixel as "set" when its value is strictly above 12'h000 and strictly below 12'hFFF.
REQ-018 SHALL register both set flags one cycle after sampling, then latch a sticky collision flag when both flags are set, video_on was high, and game_state is RUN.
REQ-019 SHALL generate frame_tick, a one-cycle internal pulse, on the cycle after video_on=1 with pix_row=479 and pix_col=639.
REQ-020 SHALL detect the rising edge of start_btn with a registered previous value; only edges count.
REQ-021 IDLE: on start edge -> RUN, score=0, lives=LIVES_INIT, road_scroll=0, collision flag cleared.
REQ-022 RUN, on frame_tick without collision: road_scroll = (road_scroll + traffic_speed) mod ROAD_HEIGHT, and score += 1, saturating at SCORE_MAX.
REQ-023 RUN, on frame_tick with collision latched: crash_pulse=1 for that cycle, lives -= 1, collision flag cleared, score and road_scroll unchanged; if lives was 1 -> OVER, else -> CRASH with frame counter=0.
REQ-024 CRASH: road_scroll and score frozen, collisions ignored; frame counter increments on each frame_tick; on the tick where it reaches CRASH_FRAMES-1 -> RUN.
REQ-025 OVER: outputs hold; on start edge -> RUN with the REQ-021 initialisation applied in one step.
REQ-026 traffic_speed SHALL be 0 in IDLE and OVER; otherwise min(7, 2 + score/1024), integer division.
REQ-027 A start edge in RUN or CRASH SHALL be ignored.
REQ-028 When frame_tick and a new collision flag set coincide, the collision SHALL be sampled at the next frame_tick.
REQ-029 Scroll wrap SHALL use compare-and-subtract; no intermediate sum may exceed 10 bits plus 1.

Reset
REQ-030 Reset SHALL force game_state=IDLE, road_scroll=0, score=0, lives=LIVES_INIT, crash_pulse=0, traffic_speed=0, and clear the collision flag, frame counter and start-edge register, asynchronously.
REQ-031 Reset asserted mid-frame or mid-CRASH SHALL discard all progress; the first frame_tick after release SHALL be decoded normally.

Structure
REQ-032 State encodings, the BLACK/WHITE colour constants, and the 640x480 active-area limits SHALL live in a shared race_pkg package.
REQ-033 Collision detection (REQ-017, REQ-018) SHALL be one sub-module, collision_detect, with a sticky output and a clear input.

Verification
REQ-034 Scenario: reset released, start edge -> RUN next cycle; lives=3; after 10 clean frames, score=10 and road_scroll=20.
REQ-035 Scenario: RUN with road_scroll=478, speed 2 -> 0 at next frame_tick.
REQ-036 Scenario: player_car_in=moving_cars_in=12'h0F0 at one active pixel -> at frame_tick, crash_pulse=1, lives 3->2, state CRASH; RUN after 120 ticks.
REQ-037 Scenario: overlap using 12'hFFF on one layer -> no collision.
REQ-038 Scenario: third collision -> state OVER with speed 0; start edge -> RUN, score 0, lives 3.
REQ-039 Scenario: score forced to 9999 -> stays at 9999 after frame_tick, speed 7; reset asserted mid-CRASH -> IDLE immediately.
